// File: rtl/wb_trace_fifo_if.sv
// rtl/wb_trace_fifo_if.sv - writeback commit capture and trace consumer bundle (trace_seq under WB_TRACE_SEQ_EN)
interface wb_trace_fifo_if;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic        trace_ready;
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [3:0]  trace_wen;
    logic [4:0]  trace_wnum;
    logic [31:0] trace_wdata;
`ifdef WB_TRACE_SEQ_EN
    logic [31:0] trace_seq;
`endif

    modport master (
        output debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata, trace_ready,
`ifdef WB_TRACE_SEQ_EN
        input  trace_seq,
`endif
        input  trace_valid, trace_pc, trace_wen, trace_wnum, trace_wdata
    );

    modport slave (
        input  debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata, trace_ready,
`ifdef WB_TRACE_SEQ_EN
        output trace_seq,
`endif
        output trace_valid, trace_pc, trace_wen, trace_wnum, trace_wdata
    );
endinterface

// File: rtl/wb_trace_fifo.sv
// rtl/wb_trace_fifo.sv - FWFT trace FIFO of register-file commits with sticky overflow; WB_TRACE_SEQ_EN adds trace_seq
module wb_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    wb_trace_fifo_if.slave   wb,
    input  logic             overflow_clr,
    output logic [CNT_W-1:0] fifo_count,
    output logic             fifo_full,
    output logic             overflow
);
    localparam int PTR_W = $clog2(DEPTH);
`ifdef WB_TRACE_SEQ_EN
    localparam int ENT_W = 105;
`else
    localparam int ENT_W = 73;
`endif

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [ENT_W-1:0] wr_entry, head;
    logic             push, pop, accept, drop;

    assign push = (wb.debug_wb_rf_wen != 4'b0) && (wb.debug_wb_rf_wnum != 5'd0);
    assign pop  = wb.trace_valid && wb.trace_ready;
    // A full FIFO still takes the push when the head leaves on the same edge.
    assign accept = push && (!fifo_full || pop);
    assign drop   = push && fifo_full && !pop;

    assign fifo_full      = (fifo_count == CNT_W'(DEPTH));
    assign wb.trace_valid = (fifo_count != '0);
    assign head           = wb.trace_valid ? mem[rd_ptr] : '0;

`ifdef WB_TRACE_SEQ_EN
    logic [31:0] seq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_q <= '0;
        end else if (push) begin
            seq_q <= seq_q + 32'd1;
        end
    end

    assign wr_entry     = {seq_q, wb.debug_wb_pc, wb.debug_wb_rf_wen, wb.debug_wb_rf_wnum, wb.debug_wb_rf_wdata};
    assign wb.trace_seq = head[104:73];
`else
    assign wr_entry = {wb.debug_wb_pc, wb.debug_wb_rf_wen, wb.debug_wb_rf_wnum, wb.debug_wb_rf_wdata};
`endif

    assign wb.trace_pc    = head[72:41];
    assign wb.trace_wen   = head[40:37];
    assign wb.trace_wnum  = head[36:32];
    assign wb.trace_wdata = head[31:0];

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({accept, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_wb_trace_fifo.sv
// tb/tb_wb_trace_fifo.sv - randomized and directed bench for wb_trace_fifo against a queue model
module tb_wb_trace_fifo;
    localparam int DEPTH = 16;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             overflow_clr;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             overflow;

    wb_trace_fifo_if wbi ();

    wb_trace_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .wb           (wbi.slave),
        .overflow_clr (overflow_clr),
        .fifo_count   (fifo_count),
        .fifo_full    (fifo_full),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  wen;
        logic [4:0]  wnum;
        logic [31:0] wdata;
        logic [31:0] seq;
    } ent_t;

    ent_t        mq[$];
    bit          m_ovf;
    logic [31:0] m_seq;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input logic [31:0] pc, input logic [3:0] wen, input logic [4:0] wnum,
                              input logic [31:0] wdata, input bit ready, input bit clr, input bit r);
        bit   do_push, do_pop, was_full;
        ent_t e;
        if (r) begin
            mq.delete();
            m_ovf = 0;
            m_seq = '0;
            return;
        end
        do_push  = (wen != 0) && (wnum != 0);
        do_pop   = (mq.size() != 0) && ready;
        was_full = (mq.size() == DEPTH);
        if (clr) m_ovf = 0;
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            e = '{pc: pc, wen: wen, wnum: wnum, wdata: wdata, seq: m_seq};
            if (was_full && !do_pop) m_ovf = 1;
            else mq.push_back(e);
            m_seq = m_seq + 32'd1;
        end
    endtask

    task automatic check_all();
        ent_t h;
        h = (mq.size() != 0) ? mq[0] : '0;
        chk("valid", 64'(wbi.trace_valid), 64'(mq.size() != 0));
        chk("count", 64'(fifo_count), 64'(mq.size()));
        chk("full", 64'(fifo_full), 64'(mq.size() == DEPTH));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("pc", 64'(wbi.trace_pc), 64'(h.pc));
        chk("wen", 64'(wbi.trace_wen), 64'(h.wen));
        chk("wnum", 64'(wbi.trace_wnum), 64'(h.wnum));
        chk("wdata", 64'(wbi.trace_wdata), 64'(h.wdata));
`ifdef WB_TRACE_SEQ_EN
        chk("seq", 64'(wbi.trace_seq), 64'(h.seq));
`endif
    endtask

    task automatic drive(input logic [31:0] pc, input logic [3:0] wen, input logic [4:0] wnum,
                         input logic [31:0] wdata, input bit ready, input bit clr, input bit r);
        wbi.debug_wb_pc       = pc;
        wbi.debug_wb_rf_wen   = wen;
        wbi.debug_wb_rf_wnum  = wnum;
        wbi.debug_wb_rf_wdata = wdata;
        wbi.trace_ready       = ready;
        overflow_clr          = clr;
        rst                   = r;
        model_step(pc, wen, wnum, wdata, ready, clr, r);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input bit ready, input bit clr);
        drive($urandom, 4'h0, 5'($urandom), $urandom, ready, clr, 1'b0);
    endtask

    task automatic commit(input logic [31:0] wdata, input bit ready, input bit clr);
        drive($urandom, 4'hF, 5'($urandom_range(1, 31)), wdata, ready, clr, 1'b0);
    endtask

    initial begin
        wbi.debug_wb_pc       = '0;
        wbi.debug_wb_rf_wen   = '0;
        wbi.debug_wb_rf_wnum  = '0;
        wbi.debug_wb_rf_wdata = '0;
        wbi.trace_ready       = 1'b0;
        overflow_clr          = 1'b0;
        rst                   = 1'b1;

        drive('0, 4'h0, 5'd0, '0, 1'b0, 1'b0, 1'b1);
        drive('0, 4'h0, 5'd0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) idle(1'b0, 1'b0);
        chk("idle_valid", 64'(wbi.trace_valid), 64'd0);
        chk("idle_pc", 64'(wbi.trace_pc), 64'd0);

        drive(32'hBFC0_0000, 4'hF, 5'd5, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        chk("one_valid", 64'(wbi.trace_valid), 64'd1);
        chk("one_pc", 64'(wbi.trace_pc), 64'hBFC0_0000);
        chk("one_wnum", 64'(wbi.trace_wnum), 64'd5);
        for (int i = 0; i < 3; i++) idle(1'b0, 1'b0);
        chk("one_hold", 64'(wbi.trace_wdata), 64'h1234_5678);
        idle(1'b1, 1'b0);
        chk("one_drained", 64'(fifo_count), 64'd0);

        drive(32'h100, 4'hF, 5'd0, 32'hDEAD, 1'b0, 1'b0, 1'b0);
        drive(32'h104, 4'h0, 5'd3, 32'hBEEF, 1'b0, 1'b0, 1'b0);
        chk("no_capture", 64'(fifo_count), 64'd0);

        for (int i = 1; i <= 16; i++) commit(32'(i), 1'b0, 1'b0);
        chk("fill_full", 64'(fifo_full), 64'd1);
        commit(32'd17, 1'b0, 1'b0);
        chk("drop_ovf", 64'(overflow), 64'd1);
        chk("drop_cnt", 64'(fifo_count), 64'd16);
        for (int i = 1; i <= 16; i++) begin
            chk("drain_order", 64'(wbi.trace_wdata), 64'(i));
            idle(1'b1, 1'b0);
        end
        chk("drain_empty", 64'(wbi.trace_valid), 64'd0);

        idle(1'b0, 1'b1);
        for (int i = 1; i <= 16; i++) commit(32'(100 + i), 1'b0, 1'b0);
        commit(32'hAA, 1'b1, 1'b0);
        chk("pp_cnt", 64'(fifo_count), 64'd16);
        chk("pp_ovf", 64'(overflow), 64'd0);
        commit(32'hBB, 1'b0, 1'b0);
        chk("drop2_ovf", 64'(overflow), 64'd1);
        commit(32'hCC, 1'b0, 1'b1);
        chk("set_wins", 64'(overflow), 64'd1);
        idle(1'b0, 1'b1);
        chk("clr_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < 15; i++) idle(1'b1, 1'b0);
        chk("pp_last", 64'(wbi.trace_wdata), 64'hAA);
        idle(1'b1, 1'b0);
        chk("pp_empty", 64'(wbi.trace_valid), 64'd0);

        drive('0, 4'h0, 5'd0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            commit(32'(i), 1'b1, 1'b0);
            chk("stream_cnt_le1", 64'(fifo_count <= 1), 64'd1);
            chk("stream_order", 64'(wbi.trace_wdata), 64'(i));
`ifdef WB_TRACE_SEQ_EN
            chk("stream_seq", 64'(wbi.trace_seq), 64'(i));
`endif
        end
        idle(1'b1, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            int          phase;
            bit          ready;
            logic [3:0]  wen;
            logic [4:0]  wnum;
            phase = (i / 250) % 4;
            case (phase)
                0:       ready = ($urandom_range(0, 9) < 2);
                1:       ready = ($urandom_range(0, 9) < 8);
                2:       ready = 1'b0;
                default: ready = $urandom_range(0, 1) != 0;
            endcase
            wen  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            wnum = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            drive($urandom, wen, wnum, $urandom, ready, ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 499) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
